servo_angle_ramp: RTL and testbench

Upstream stage of the servo PWM generator: converts discrete target-angle commands into a slew-limited angle stream.
- Accepts a command angle via valid/ready handshake.
- Steps its `angle` output toward the target by at most STEP_DEG per servo frame (20 ms).
- Drives the PWM generator's 8-bit angle input directly.
- Reports busy / settled status to the controlling FSM.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_angle_ramp_if.sv | 11 +
 rtl/servo_frame_tick.sv | 28 ++
 rtl/servo_angle_ramp.sv | 137 +++++++++++++
 tb/tb_servo_angle_ramp.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants, ramp state encoding and angle clamp helper.
// Also used by the PWM generator so both agree on the frame period.
package servo_pkg;

  localparam int unsigned ANGLE_W             = 8;
  localparam int unsigned MAX_ANGLE           = 180;
  localparam int unsigned TICK_CYCLES_DEFAULT = 1000000;
  localparam int unsigned SETTLE_W            = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SETTLE = 2'd2
  } ramp_state_e;

  // Saturate a requested angle to the mechanical range.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    return (a > ANGLE_W'(MAX_ANGLE)) ? ANGLE_W'(MAX_ANGLE) : a;
  endfunction

endpackage

// File: rtl/servo_angle_ramp_if.sv
// Command handshake between the controlling FSM (master) and the angle ramp (slave).
interface servo_angle_ramp_if;

  logic                             cmd_valid;
  logic [servo_pkg::ANGLE_W-1:0]    cmd_angle;
  logic                             cmd_ready;

  modport master (output cmd_valid, output cmd_angle, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_angle, output cmd_ready);

endinterface

// File: rtl/servo_frame_tick.sv
// Free-running servo frame counter with a registered one-cycle boundary pulse.
module servo_frame_tick #(
  parameter int unsigned TICK_CYCLES = servo_pkg::TICK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      frame_tick <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/servo_angle_ramp.sv
// Slew-limited servo angle ramp: steps angle toward the commanded target once per frame.
// Optional SERVO_RAMP_CMD_ERR_EN rejects out-of-range commands and flags them on cmd_err.
module servo_angle_ramp
  import servo_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = TICK_CYCLES_DEFAULT,
  parameter int unsigned STEP_DEG      = 2,
  parameter int unsigned INIT_ANGLE    = 90,
  parameter int unsigned SETTLE_FRAMES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  servo_angle_ramp_if.slave  cmd,
  output logic [ANGLE_W-1:0] angle,
  output logic               frame_tick,
  output logic               busy,
  output logic               at_target
`ifdef SERVO_RAMP_CMD_ERR_EN
  ,
  output logic               cmd_err
`endif
);

  localparam int unsigned DIFF_W = ANGLE_W + 1;
  localparam logic [ANGLE_W-1:0]  INIT_A   = ANGLE_W'(INIT_ANGLE);
  localparam logic [ANGLE_W-1:0]  STEP_A   = ANGLE_W'(STEP_DEG);
  localparam logic [DIFF_W-1:0]   STEP_D   = DIFF_W'(STEP_DEG);
  localparam logic [SETTLE_W-1:0] SETTLE_N = SETTLE_W'(SETTLE_FRAMES);

  ramp_state_e          state_q, state_d;
  logic [ANGLE_W-1:0]   target_q, target_d;
  logic [ANGLE_W-1:0]   angle_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 cmd_err_d;

  logic                 accept_c;
  logic                 take_c;
  logic [ANGLE_W-1:0]   new_target_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic [DIFF_W-1:0]    mag_c;

  servo_frame_tick #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_frame_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign accept_c     = cmd.cmd_valid && cmd.cmd_ready;
  assign new_target_c = clamp_angle(cmd.cmd_angle);

  // Out-of-range commands are either dropped with an error pulse or clamped and executed.
`ifdef SERVO_RAMP_CMD_ERR_EN
  logic in_range_c;
  assign in_range_c = (cmd.cmd_angle <= ANGLE_W'(MAX_ANGLE));
  assign take_c     = accept_c && in_range_c;
`else
  assign take_c     = accept_c;
`endif

  // Signed distance to target; 9 bits holds -180..180 without wrap.
  assign diff_c = $signed({1'b0, target_q}) - $signed({1'b0, angle});
  assign mag_c  = diff_c[DIFF_W-1] ? $unsigned(-diff_c) : $unsigned(diff_c);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    angle_d   = angle;
    settle_d  = settle_q;
    cmd_err_d = 1'b0;
`ifdef SERVO_RAMP_CMD_ERR_EN
    cmd_err_d = accept_c && !in_range_c;
`endif
    case (state_q)
      IDLE, SETTLE: begin
        if (take_c) begin
          target_d = new_target_c;
          settle_d = '0;
          state_d  = (new_target_c == angle) ? SETTLE : MOVING;
        end else if (state_q == SETTLE) begin
          if (SETTLE_N == '0) begin
            state_d = IDLE;
          end else if (frame_tick) begin
            if (settle_q == SETTLE_N - SETTLE_W'(1)) begin
              state_d = IDLE;
            end else begin
              settle_d = settle_q + SETTLE_W'(1);
            end
          end
        end
      end
      MOVING: begin
        if (frame_tick) begin
          if (mag_c <= STEP_D) begin
            angle_d  = target_q;
            settle_d = '0;
            state_d  = SETTLE;
          end else if (diff_c[DIFF_W-1]) begin
            angle_d = angle - STEP_A;
          end else begin
            angle_d = angle + STEP_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      target_q      <= INIT_A;
      angle         <= INIT_A;
      settle_q      <= '0;
      cmd.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      at_target     <= 1'b1;
`ifdef SERVO_RAMP_CMD_ERR_EN
      cmd_err       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      angle         <= angle_d;
      settle_q      <= settle_d;
      cmd.cmd_ready <= (state_d != MOVING);
      busy          <= (state_d != IDLE);
      at_target     <= (state_d == IDLE);
`ifdef SERVO_RAMP_CMD_ERR_EN
      cmd_err       <= cmd_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with a short frame (TICK_CYCLES=10).
module tb_servo_angle_ramp;

  localparam int unsigned TICK   = 10;
  localparam int unsigned STEP   = 2;
  localparam int unsigned INIT   = 90;
  localparam int unsigned SETTLE = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] angle;
  logic       frame_tick;
  logic       busy;
  logic       at_target;
`ifdef SERVO_RAMP_CMD_ERR_EN
  logic       cmd_err;
`endif

  int checks   = 0;
  int failures = 0;

  servo_angle_ramp_if cmd_if ();

  servo_angle_ramp #(
    .TICK_CYCLES   (TICK),
    .STEP_DEG      (STEP),
    .INIT_ANGLE    (INIT),
    .SETTLE_FRAMES (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if.slave),
    .angle      (angle),
    .frame_tick (frame_tick),
    .busy       (busy),
    .at_target  (at_target)
`ifdef SERVO_RAMP_CMD_ERR_EN
    ,
    .cmd_err    (cmd_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_angle = 8'd0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] a);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_angle = a;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Returns at the negedge of the next cycle with frame_tick high (current cycle included).
  task automatic wait_tick(input string tag);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_tick_timeout: frame_tick not seen within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    do_reset();
    checks++;
    if (angle !== 8'd90 || at_target !== 1'b1 || busy !== 1'b0 ||
        cmd_if.cmd_ready !== 1'b1 || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: angle=%0d at_target=%b busy=%b ready=%b tick=%b, want 90 1 0 1 0",
               angle, at_target, busy, cmd_if.cmd_ready, frame_tick);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL reset_first_tick: tick after %0d cycles, want 10", n);
    end
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_width: frame_tick=%b one cycle later, want 0", frame_tick);
    end
    n = 1;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL tick_period: period %0d cycles, want 10", n);
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp;
    do_reset();
    send_cmd(8'd100);
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1 || at_target !== 1'b0) begin
      failures++;
      $display("FAIL up_accept: ready=%b busy=%b at_target=%b, want 0 1 0",
               cmd_if.cmd_ready, busy, at_target);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_tick("up");
      @(negedge clk);
      exp = 8'(90 + 2 * k);
      checks++;
      if (angle !== exp || cmd_if.cmd_ready !== (k == 5)) begin
        failures++;
        $display("FAIL up_step%0d: angle=%0d ready=%b, want %0d %b",
                 k, angle, cmd_if.cmd_ready, exp, (k == 5));
      end
    end
    for (int s = 1; s <= 3; s++) begin
      wait_tick("up_settle");
      @(negedge clk);
      checks++;
      if (at_target !== (s == 3) || busy !== (s != 3) || angle !== 8'd100) begin
        failures++;
        $display("FAIL up_settle%0d: at_target=%b busy=%b angle=%0d, want %b %b 100",
                 s, at_target, busy, angle, (s == 3), (s != 3));
      end
    end
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'd88; exp_seq[1] = 8'd86; exp_seq[2] = 8'd85; exp_seq[3] = 8'd85;
    do_reset();
    send_cmd(8'd85);
    for (int k = 0; k < 4; k++) begin
      wait_tick("down");
      @(negedge clk);
      checks++;
      if (angle !== exp_seq[k]) begin
        failures++;
        $display("FAIL down_step%0d: angle=%0d, want %0d", k, angle, exp_seq[k]);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    send_cmd(8'd200);
`ifdef SERVO_RAMP_CMD_ERR_EN
    checks++;
    if (cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL err_pulse: cmd_err=%b, want 1", cmd_err);
    end
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0 || angle !== 8'd90 || busy !== 1'b0 || at_target !== 1'b1) begin
      failures++;
      $display("FAIL err_after: cmd_err=%b angle=%0d busy=%b at_target=%b, want 0 90 0 1",
               cmd_err, angle, busy, at_target);
    end
    wait_tick("err");
    @(negedge clk);
    checks++;
    if (angle !== 8'd90) begin
      failures++;
      $display("FAIL err_hold: angle=%0d, want 90", angle);
    end
`else
    begin
      int exp = 90;
      for (int k = 1; k <= 46; k++) begin
        wait_tick("clamp");
        @(negedge clk);
        exp = (exp + 2 > 180) ? 180 : exp + 2;
        checks++;
        if (angle !== 8'(exp)) begin
          failures++;
          $display("FAIL clamp_step%0d: angle=%0d, want %0d", k, angle, exp);
        end
      end
    end
`endif
  endtask

  task automatic test_hold_valid();
    int n;
    do_reset();
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_angle = 8'd94;
    @(negedge clk);
    cmd_if.cmd_angle = 8'd80;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || angle !== 8'd94 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_reach: ready=%b angle=%0d busy=%b, want 1 94 1",
               cmd_if.cmd_ready, angle, busy);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1 || angle !== 8'd94) begin
      failures++;
      $display("FAIL hold_retarget: ready=%b busy=%b angle=%0d, want 0 1 94",
               cmd_if.cmd_ready, busy, angle);
    end
    wait_tick("hold");
    @(negedge clk);
    checks++;
    if (angle !== 8'd92) begin
      failures++;
      $display("FAIL hold_step: angle=%0d, want 92", angle);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL coin_phase: frame_tick=%b, want 1", frame_tick);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_angle = 8'd96;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (angle !== 8'd90 || busy !== 1'b1) begin
      failures++;
      $display("FAIL coin_nostep: angle=%0d busy=%b, want 90 1", angle, busy);
    end
    repeat (9) @(negedge clk);
    @(negedge clk);
    checks++;
    if (angle !== 8'd92) begin
      failures++;
      $display("FAIL coin_first_step: angle=%0d, want 92", angle);
    end
  endtask

  task automatic test_same_angle();
    do_reset();
    send_cmd(8'd90);
    checks++;
    if (busy !== 1'b1 || at_target !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || angle !== 8'd90) begin
      failures++;
      $display("FAIL same_accept: busy=%b at_target=%b ready=%b angle=%0d, want 1 0 1 90",
               busy, at_target, cmd_if.cmd_ready, angle);
    end
    for (int s = 1; s <= 3; s++) begin
      wait_tick("same");
      @(negedge clk);
      checks++;
      if (at_target !== (s == 3) || angle !== 8'd90) begin
        failures++;
        $display("FAIL same_settle%0d: at_target=%b angle=%0d, want %b 90",
                 s, at_target, angle, (s == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_cmd(8'd120);
    wait_tick("mid");
    @(negedge clk);
    wait_tick("mid");
    @(negedge clk);
    checks++;
    if (angle !== 8'd94) begin
      failures++;
      $display("FAIL mid_progress: angle=%0d, want 94", angle);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (angle !== 8'd90 || busy !== 1'b0 || at_target !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async_reset: angle=%0d busy=%b at_target=%b ready=%b, want 90 0 1 1",
               angle, busy, at_target, cmd_if.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (angle !== 8'd90 || at_target !== 1'b1) begin
      failures++;
      $display("FAIL mid_target_dropped: angle=%0d at_target=%b, want 90 1", angle, at_target);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_angle = 8'd0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_hold_valid();
    test_coincident();
    test_same_angle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
